// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle sequencer for the VeriRisc core.
// An 8-phase counter walks every instruction through fetch, decode and
// execute. Each phase, together with the opcode and the accumulator-zero
// flag, is decoded into the control strobes for PC, IR, accumulator, memory
// and the data-bus driver. A HLT seen in the operand-address phase freezes
// the sequencer until reset.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  // Phase encodings
  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // Opcode encodings
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;
  logic       halt_now;
  logic       alu_op;
  logic       is_hlt, is_skz, is_sto, is_jmp;

  // Opcode classification shared by the strobe decode
  always_comb begin
    is_hlt = (opcode == OP_HLT);
    is_skz = (opcode == OP_SKZ);
    is_sto = (opcode == OP_STO);
    is_jmp = (opcode == OP_JMP);
    alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
             (opcode == OP_XOR) || (opcode == OP_LDA);
  end

  // Next-state: advance the phase unless halted or about to halt
  always_comb begin
    halt_now = !halted_q && (phase_q == PH_OP_ADDR) && is_hlt;
    halted_d = halted_q || halt_now;
    // Freezing on the halting edge keeps the counter parked at phase 4.
    phase_d  = (halted_q || halt_now) ? phase_q : phase_q + 3'd1;
  end

  // State registers with asynchronous reset
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Control-strobe decode from phase, halted flag, opcode and zero
  // NOTE: every output gets a default first so no path through the case
  // leaves a strobe unassigned, which would otherwise infer a latch.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = !is_hlt;
          halt   = is_hlt;
        end
        PH_OP_FETCH: begin
          rd = alu_op;
        end
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          inc_pc = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for the VeriRisc instruction sequencer.
// Strobe vectors are packed as {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr,
// data_e, halt}; per-phase tables are written out by hand per opcode.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  cpu_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe constants
  localparam logic [8:0] S_RST  = 9'b100000000; // phase 0 / reset
  localparam logic [8:0] S_P1   = 9'b110000000;
  localparam logic [8:0] S_P23  = 9'b111000000;
  localparam logic [8:0] S_INC  = 9'b000100000;
  localparam logic [8:0] S_RD   = 9'b010000000;
  localparam logic [8:0] S_RDAC = 9'b010001000;
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_DE   = 9'b000000010;
  localparam logic [8:0] S_WRDE = 9'b000000110;
  localparam logic [8:0] S_LDPC = 9'b000010000;
  localparam logic [8:0] S_JMP7 = 9'b000110000;
  localparam logic [8:0] S_HALT = 9'b000000001;

  // Tables listed phase 7 down to phase 0
  localparam logic [7:0][8:0] T_ADD =
    {S_RDAC, S_RD, S_RD, S_INC, S_P23, S_P23, S_P1, S_RST};
  localparam logic [7:0][8:0] T_STO =
    {S_WRDE, S_DE, S_NONE, S_INC, S_P23, S_P23, S_P1, S_RST};
  localparam logic [7:0][8:0] T_SKZ1 =
    {S_NONE, S_INC, S_NONE, S_INC, S_P23, S_P23, S_P1, S_RST};
  localparam logic [7:0][8:0] T_SKZ0 =
    {S_NONE, S_NONE, S_NONE, S_INC, S_P23, S_P23, S_P1, S_RST};
  localparam logic [7:0][8:0] T_JMP =
    {S_JMP7, S_LDPC, S_NONE, S_INC, S_P23, S_P23, S_P1, S_RST};

  function automatic logic [8:0] strobes();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check phase and strobes against one expected pair
  task automatic expect_state(input string name, input logic [2:0] exp_phase,
                              input logic [8:0] exp_str);
    checks++;
    if (phase !== exp_phase) begin
      errors++;
      $display("FAIL %s: phase got %0d expected %0d", name, phase, exp_phase);
    end
    checks++;
    if (strobes() !== exp_str) begin
      errors++;
      $display("FAIL %s: phase %0d strobes got %b expected %b",
               name, exp_phase, strobes(), exp_str);
    end
  endtask

  // Run phases first..last of an instruction, starting at phase 'first'
  task automatic run_phases(input string name, input logic [2:0] op,
                            input logic z, input logic [7:0][8:0] tbl,
                            input int first, input int last);
    opcode = op;
    zero   = z;
    for (int p = first; p <= last; p++) begin
      expect_state(name, 3'(p), tbl[p]);
      step();
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    #2;
    expect_state("reset_initial", 3'd0, S_RST);
    step();
    step();
    expect_state("reset_held", 3'd0, S_RST);
    rst = 1'b0;
    expect_state("reset_released", 3'd0, S_RST);
  endtask

  task automatic test_add();
    run_phases("add_instr1", 3'd2, 1'b0, T_ADD, 0, 7);
    run_phases("add_instr2", 3'd2, 1'b0, T_ADD, 0, 7);
  endtask

  task automatic test_sto();
    run_phases("sto", 3'd6, 1'b0, T_STO, 0, 7);
  endtask

  task automatic test_skz();
    run_phases("skz_zero1", 3'd1, 1'b1, T_SKZ1, 0, 7);
    run_phases("skz_zero0", 3'd1, 1'b0, T_SKZ0, 0, 7);
  endtask

  task automatic test_jmp();
    run_phases("jmp", 3'd7, 1'b0, T_JMP, 0, 7);
  endtask

  // Back-to-back instructions with different opcodes, including
  // zero toggled outside phase 6 which must have no effect
  task automatic test_back_to_back();
    run_phases("b2b_lda", 3'd5, 1'b1, T_ADD, 0, 7);
    run_phases("b2b_xor", 3'd4, 1'b1, T_ADD, 0, 7);
    run_phases("b2b_sto", 3'd6, 1'b1, T_STO, 0, 7);
  endtask

  task automatic test_reset_mid();
    run_phases("mid_pre", 3'd2, 1'b0, T_ADD, 0, 4);
    // now in phase 5, one ns past the edge
    expect_state("mid_phase5", 3'd5, S_RD);
    #2;
    rst = 1'b1;
    #1;
    expect_state("mid_async_reset", 3'd0, S_RST);
    step();
    rst = 1'b0;
    run_phases("mid_resume", 3'd2, 1'b0, T_ADD, 0, 7);
  endtask

  task automatic test_halt();
    run_phases("halt_pre", 3'd2, 1'b0, T_ADD, 0, 3);
    opcode = 3'd0;
    #1;
    expect_state("halt_phase4", 3'd4, S_HALT);
    step();
    opcode = 3'd2;
    for (int i = 0; i < 20; i++) begin
      zero = i[0];
      #1;
      expect_state("halt_frozen", 3'd4, S_HALT);
      step();
    end
    // Reset while halted, before the next edge
    #2;
    rst = 1'b1;
    #1;
    expect_state("halt_async_reset", 3'd0, S_RST);
    step();
    rst = 1'b0;
    run_phases("halt_resume", 3'd2, 1'b0, T_ADD, 0, 7);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sto();
    test_skz();
    test_jmp();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle sequencer for the VeriRisc core. A free-running 3-bit phase counter steps through the eight phases of every instruction. In each phase it decodes the current opcode and the accumulator-zero flag into the control strobes that drive the program counter (`inc_pc`, `ld_pc`), the instruction register, the accumulator, memory read/write and the data-bus driver. It also latches the HLT condition, which freezes the core until reset.

## Interface
- No parameters. Opcode width is fixed at 3 bits and the phase count is fixed at 8.

- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `opcode` in 3: current instruction opcode from the IR.
  - 0=HLT, 1=SKZ, 2=ADD, 3=AND, 4=XOR, 5=LDA, 6=STO, 7=JMP.
- `zero` in 1: accumulator-zero flag.
- `sel` out 1: address mux select (1 = PC, 0 = IR operand).
- `rd` out 1: memory read strobe.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: program counter enable.
- `ld_pc` out 1: program counter load.
- `ld_ac` out 1: accumulator load.
- `wr` out 1: memory write strobe.
- `data_e` out 1: data-bus output enable.
- `halt` out 1: core halted.
- `phase` out 3: current phase number.

## Operation
- State consists of the `phase` register (0–7) and the `halted` flag.
- Each clock, `phase` increments and wraps from 7 to 0, unless `halted` is set.
- `halted` is set on the clock edge that ends phase 4 when `opcode`=HLT.
  - Once set, `phase` holds at 4 and `halted` stays 1 until reset.
- Outputs are combinational decodes of `phase`, `halted`, `opcode` and `zero`.
  - ALUOP = `opcode` in {ADD, AND, XOR, LDA}.
- Phase 0, INST_ADDR: `sel`=1.
- Phase 1, INST_FETCH: `sel`=1, `rd`=1.
- Phase 2, INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
- Phase 3, IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
- Phase 4, OP_ADDR:
  - `inc_pc` = (`opcode`!=HLT).
  - `halt` = (`opcode`==HLT).
- Phase 5, OP_FETCH: `rd` = ALUOP.
- Phase 6, ALU_OP:
  - `rd` = ALUOP.
  - `inc_pc` = (SKZ and `zero`).
  - `ld_pc` = JMP.
  - `data_e` = STO.
- Phase 7, STORE:
  - `rd` = ALUOP, `ld_ac` = ALUOP.
  - `ld_pc` = JMP, `inc_pc` = JMP.
  - `wr` = STO, `data_e` = STO.
- All strobes not listed for a phase are 0.
- While `halted`=1: `halt`=1 and every other strobe is 0, regardless of `opcode` or `zero`. `phase` reads 4.
- Illegal or X values on `opcode` are not possible; every 3-bit value is decoded.

## Timing
- Reset asserted: `phase`=0 and `halted`=0 immediately, without waiting for a clock.
  - Outputs during reset: `sel`=1, all other strobes 0, `halt`=0.
- First rising edge after `rst` deasserts moves `phase` to 1.
- One instruction takes exactly 8 cycles, with no stalls.
- IR loads on the edge ending phase 3. `opcode` must be stable from phase 4 onward.
- `zero` is sampled combinationally during phase 6 only.
- HLT:
  - `halt` rises combinationally in phase 4.
  - The following edge sets `halted`; the counter never leaves phase 4.
- SKZ with `zero`=1: PC advances twice per instruction, once in phase 4 and once in phase 6.
- JMP: `ld_pc` is high in both phases 6 and 7. Load has priority over enable in the counter, so PC ends at the operand.
- Reset mid-instruction, in any phase or while halted: returns to phase 0 with `halted`=0, asynchronously.

## Test plan
- Reset, then 16 clocks with `opcode`=ADD, `zero`=0 -> `phase` sequence 0,1,…,7,0,…,7.
  - `ld_ac`=1 only in phase 7.
  - `inc_pc`=1 only in phase 4.
  - `wr` and `ld_pc` never asserted.
- `opcode`=STO for one instruction -> `data_e`=1 in phases 6 and 7, `wr`=1 in phase 7 only, `rd`=0 in phases 5–7.
- `opcode`=SKZ:
  - `zero`=1 -> `inc_pc` high in phases 4 and 6.
  - `zero`=0 -> `inc_pc` high in phase 4 only.
- `opcode`=JMP -> `ld_pc`=1 in phases 6 and 7, `inc_pc`=1 in phase 7, `rd`=0 in phases 5–7.
- `opcode`=HLT at phase 4 -> `halt`=1 and `inc_pc`=0. Then hold `opcode` at ADD for 20 clocks -> `phase` stays 4, `halt` stays 1, all other strobes 0.
- Assert `rst` asynchronously mid-phase 5, and separately while halted -> `phase`=0 and `halt`=0 before the next edge. Normal sequencing resumes after release.
